// File: rtl/full_adder_if.sv
// Operand, result and handshake bundle for full_adder; clock and reset stay plain ports.
// master drives operands and controls, slave (the adder) drives the results.
interface full_adder_if #(
  parameter int unsigned WIDTH = 1
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             in_valid;
  logic             serial_en;
  logic             start;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             out_valid;

  modport master (
    output a, b, cin, in_valid, serial_en, start,
    input  sum, cout, sum_q, cout_q, ovf_q, out_valid
  );

  modport slave (
    input  a, b, cin, in_valid, serial_en, start,
    output sum, cout, sum_q, cout_q, ovf_q, out_valid
  );
endinterface

// File: rtl/full_adder.sv
// WIDTH-bit adder: zero-latency combinational sum plus a registered, valid-qualified copy
// whose stored carry can chain WIDTH-bit slices of a longer serial addition.
module full_adder #(
  parameter int unsigned WIDTH = 1
) (
  input logic         clk,
  input logic         rst_n,
  full_adder_if.slave bus
);
  localparam int unsigned Msb = WIDTH - 1;

  logic [WIDTH:0]   comb_sum;
  logic [WIDTH:0]   reg_sum;
  logic             c_eff;
  logic             ovf_d;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             ovf_q;
  logic             valid_q;

  assign comb_sum = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.cin};
  assign bus.sum  = comb_sum[WIDTH-1:0];
  assign bus.cout = comb_sum[WIDTH];

  // Later slices of a serial add take the carry left by the last captured slice.
  always_comb begin
    c_eff   = (bus.serial_en && !bus.start) ? carry_q : bus.cin;
    reg_sum = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, c_eff};
    ovf_d   = (bus.a[Msb] == bus.b[Msb]) && (reg_sum[Msb] != bus.a[Msb]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        sum_q   <= reg_sum[WIDTH-1:0];
        carry_q <= reg_sum[WIDTH];
        ovf_q   <= ovf_d;
      end
    end
  end

  assign bus.sum_q     = sum_q;
  assign bus.cout_q    = carry_q;
  assign bus.ovf_q     = ovf_q;
  assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_full_adder.sv
// Scoreboard bench for full_adder at WIDTH 1, 4 and 8: a posedge model pushes expected
// results, a negedge monitor pops them whenever out_valid is expected.
module tb_full_adder;
  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mon_en = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  exp_t exp_q [3][$];
  exp_t last [3];
  logic carry [3];

  always #5 clk = ~clk;

  full_adder_if #(.WIDTH(1)) if1 ();
  full_adder_if #(.WIDTH(4)) if4 ();
  full_adder_if #(.WIDTH(8)) if8 ();

  full_adder #(.WIDTH(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  full_adder #(.WIDTH(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  full_adder #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(if8));

  function automatic int wid(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 4 : 8);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference: plain integer arithmetic, signed overflow as a range check.
  task automatic model_step(input int d, input logic [7:0] a, input logic [7:0] b,
                            input logic ci, input logic v, input logic se, input logic st);
    int   w, full, half, r, sa, sb, s;
    logic ce;
    exp_t e;
    w    = wid(d);
    full = 1 << w;
    half = 1 << (w - 1);
    if (!rst_n) begin
      carry[d] = 1'b0;
      last[d]  = '0;
      exp_q[d].delete();
    end else if (v) begin
      ce     = (se && !st) ? carry[d] : ci;
      r      = int'(a) + int'(b) + int'(ce);
      sa     = (int'(a) >= half) ? int'(a) - full : int'(a);
      sb     = (int'(b) >= half) ? int'(b) - full : int'(b);
      s      = sa + sb + int'(ce);
      e.sum  = 8'(r % full);
      e.cout = (r >= full);
      e.ovf  = (s < -half) || (s >= half);
      exp_q[d].push_back(e);
      carry[d] = e.cout;
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      last[d]  = '0;
      carry[d] = 1'b0;
    end
  end

  always @(posedge clk) begin
    model_step(0, 8'(if1.a), 8'(if1.b), if1.cin, if1.in_valid, if1.serial_en, if1.start);
    model_step(1, 8'(if4.a), 8'(if4.b), if4.cin, if4.in_valid, if4.serial_en, if4.start);
    model_step(2, 8'(if8.a), 8'(if8.b), if8.cin, if8.in_valid, if8.serial_en, if8.start);
  end

  task automatic mon(input int d, input logic ov, input logic [7:0] sq, input logic cq,
                     input logic oq, input logic [7:0] a, input logic [7:0] b,
                     input logic ci, input logic [7:0] s, input logic co);
    int   w;
    logic exp_v;
    w = wid(d);
    chk($sformatf("comb_w%0d", w), 32'(s) | (32'(co) << w),
        32'(int'(a) + int'(b) + int'(ci)));
    exp_v = (exp_q[d].size() != 0);
    chk($sformatf("out_valid_w%0d", w), 32'(ov), 32'(exp_v));
    if (exp_v) last[d] = exp_q[d].pop_front();
    chk($sformatf("sum_q_w%0d", w), 32'(sq), 32'(last[d].sum));
    chk($sformatf("cout_q_w%0d", w), 32'(cq), 32'(last[d].cout));
    chk($sformatf("ovf_q_w%0d", w), 32'(oq), 32'(last[d].ovf));
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, if1.out_valid, 8'(if1.sum_q), if1.cout_q, if1.ovf_q, 8'(if1.a), 8'(if1.b),
          if1.cin, 8'(if1.sum), if1.cout);
      mon(1, if4.out_valid, 8'(if4.sum_q), if4.cout_q, if4.ovf_q, 8'(if4.a), 8'(if4.b),
          if4.cin, 8'(if4.sum), if4.cout);
      mon(2, if8.out_valid, 8'(if8.sum_q), if8.cout_q, if8.ovf_q, 8'(if8.a), 8'(if8.b),
          if8.cin, 8'(if8.sum), if8.cout);
    end
  end

  task automatic drv1(input logic a, input logic b, input logic ci, input logic v,
                      input logic se, input logic st);
    if1.a = a; if1.b = b; if1.cin = ci; if1.in_valid = v; if1.serial_en = se; if1.start = st;
  endtask

  task automatic drv4(input logic [3:0] a, input logic [3:0] b, input logic ci, input logic v,
                      input logic se, input logic st);
    if4.a = a; if4.b = b; if4.cin = ci; if4.in_valid = v; if4.serial_en = se; if4.start = st;
  endtask

  task automatic drv8(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic v,
                      input logic se, input logic st);
    if8.a = a; if8.b = b; if8.cin = ci; if8.in_valid = v; if8.serial_en = se; if8.start = st;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] tbl [8];
  int         pend;

  initial begin
    tbl = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    // Reset dominates in_valid.
    drv1(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    drv4(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    drv8(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    chk("rst_sum_q", 32'(if1.sum_q), 32'd0);
    chk("rst_cout_q", 32'(if1.cout_q), 32'd0);
    chk("rst_ovf_q", 32'(if1.ovf_q), 32'd0);
    chk("rst_out_valid", 32'(if1.out_valid), 32'd0);
    chk("rst_out_valid_w8", 32'(if8.out_valid), 32'd0);
    mon_en = 1'b1;
    rst_n  = 1'b1;
    tick();
    chk("w1_first_sum_q", 32'(if1.sum_q), 32'd1);
    chk("w1_first_cout_q", 32'(if1.cout_q), 32'd1);
    chk("w1_first_valid", 32'(if1.out_valid), 32'd1);
    drv1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // WIDTH=1 truth table, combinational only.
    for (int i = 0; i < 8; i++) begin
      {if1.a, if1.b, if1.cin} = 3'(i);
      #1;
      chk($sformatf("w1_tbl_%0d", i), 32'({if1.cout, if1.sum}), 32'(tbl[i]));
      #9;
    end
    drv1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    // WIDTH=8 wrap and signed overflow.
    drv8(8'hFF, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("w8_wrap_sum", 32'(if8.sum_q), 32'h00);
    chk("w8_wrap_cout", 32'(if8.cout_q), 32'd1);
    chk("w8_wrap_ovf", 32'(if8.ovf_q), 32'd0);
    drv8(8'h7F, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("w8_ovf_sum", 32'(if8.sum_q), 32'h80);
    chk("w8_ovf_cout", 32'(if8.cout_q), 32'd0);
    chk("w8_ovf_ovf", 32'(if8.ovf_q), 32'd1);
    drv8(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Serial 0x9F + 0x71 in two 4-bit slices, back to back.
    drv4(4'hF, 4'h1, 1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    chk("ser_s1_sum", 32'(if4.sum_q), 32'h0);
    chk("ser_s1_cout", 32'(if4.cout_q), 32'd1);
    drv4(4'h9, 4'h7, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    chk("ser_s2_sum", 32'(if4.sum_q), 32'h1);
    chk("ser_s2_cout", 32'(if4.cout_q), 32'd1);

    // Same add with a three-cycle gap; idle inputs carry junk controls.
    drv4(4'hF, 4'h1, 1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drv4(4'($urandom), 4'($urandom), 1'($urandom), 1'b0, 1'($urandom), 1'($urandom));
      tick();
      chk("gap_out_valid", 32'(if4.out_valid), 32'd0);
      chk("gap_cout_hold", 32'(if4.cout_q), 32'd1);
    end
    drv4(4'h9, 4'h7, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    chk("gap_s2_sum", 32'(if4.sum_q), 32'h1);
    chk("gap_s2_cout", 32'(if4.cout_q), 32'd1);

    // Reset between slices drops the chained carry.
    drv4(4'hF, 4'h1, 1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    drv4(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    drv4(4'h9, 4'h7, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    chk("rstser_sum", 32'(if4.sum_q), 32'h0);
    chk("rstser_cout", 32'(if4.cout_q), 32'd1);

    // Random traffic on all widths with occasional resets.
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      drv1(1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0,
           1'($urandom), $urandom_range(0, 3) == 0);
      drv4(4'($urandom), 4'($urandom), 1'($urandom), $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0);
      drv8(8'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 3) != 0,
           1'($urandom), $urandom_range(0, 3) == 0);
      tick();
    end

    rst_n = 1'b1;
    drv1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drv4(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    drv8(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    pend = exp_q[0].size() + exp_q[1].size() + exp_q[2].size();
    chk("drain", 32'(pend), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish, expected finish before %0t", $time);
    $fatal(1);
  end
endmodule

// File: doc/full_adder.md
Name: full_adder

Overview:
- WIDTH-bit full adder. Pure combinational outputs sum/cout give a+b+cin with zero latency.
- A registered copy of the result has a one-cycle valid handshake.
- An optional bit-serial mode feeds the stored carry back as carry-in, so long operands can be added one WIDTH-slice per cycle.
- Leaf arithmetic cell used by datapath adders and serial accumulators.

Parameters:
- WIDTH, 1, operand/sum width in bits (must be >= 1).

Ports:
- clk  input  1  clock; all registers update on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk edge.
- a  input  WIDTH  operand A (unsigned; also read as two's complement for ovf).
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- sum  output  WIDTH  combinational (a+b+cin)[WIDTH-1:0].
- cout  output  1  combinational carry-out, bit WIDTH of a+b+cin.
- in_valid  input  1  operands valid this cycle; captures the registered result.
- serial_en  input  1  1: registered path uses stored carry_q instead of cin (cin ignored except on start).
- start  input  1  with serial_en, first slice of a serial add: carry-in = cin.
- sum_q  output  WIDTH  registered sum.
- cout_q  output  1  registered carry-out (= carry_q).
- ovf_q  output  1  registered signed overflow of the captured slice.
- out_valid  output  1  sum_q/cout_q/ovf_q valid.

Behaviour:
- Combinational path: {cout,sum} = a + b + cin, computed at WIDTH+1 bits.
  - Depends only on a, b, cin. Ignores clk, rst_n, serial_en, start, in_valid.
  - For WIDTH=1: sum = a^b^cin, cout = a&b | a&cin | b&cin.
- Effective registered carry-in: c_eff = (serial_en && !start) ? carry_q : cin.
- Registered result: r = a + b + c_eff (WIDTH+1 bits).
- Reset (rst_n=0 at rising edge): sum_q=0, cout_q=0 (carry_q=0), ovf_q=0, out_valid=0. Reset dominates in_valid.
- Capture (rising edge, rst_n=1, in_valid=1):
  - sum_q <= r[WIDTH-1:0]
  - cout_q <= r[WIDTH]
  - ovf_q <= (a[MSB]==b[MSB]) && (r[MSB]!=a[MSB])
  - out_valid <= 1
- Latency: one cycle from in_valid to out_valid.
- in_valid=0: sum_q, cout_q, ovf_q hold; out_valid <= 0.
- Back-to-back in_valid: one result per cycle, no stalls.
- Serial mode: slice k+1 uses slice k's carry_q.
  - carry_q updates only on captured cycles, so gaps in in_valid preserve the chain.
- start with serial_en=0 has no effect.
- Reset mid-serial-operation clears carry_q; the next slice without start uses carry-in 0.
- Wrap-around: sum is modulo 2^WIDTH. The carry is reported, never saturated.
- No X propagation from unused inputs: serial_en, start are don't-care when in_valid=0.

Test Plan:
- WIDTH=1, combinational: sweep (a,b,cin) 000..111, one vector per 10 ns.
  - Required {cout,sum}: 00,01,01,10,01,10,10,11, with no clock needed.
- Reset: hold rst_n=0 two cycles with in_valid=1, a=b=cin=1 -> sum_q=0, cout_q=0, ovf_q=0, out_valid=0.
  - Release, then in_valid=1, a=1, b=1, cin=1 -> next cycle sum_q=1, cout_q=1, out_valid=1.
- WIDTH=8 registered: a=0xFF, b=0x01, cin=0 -> sum_q=0x00, cout_q=1, ovf_q=0.
  - Then a=0x7F, b=0x01 -> sum_q=0x80, cout_q=0, ovf_q=1.
- Serial, WIDTH=4, 8-bit value 0x9F + 0x71 as two slices:
  - Slice 1 (start=1, cin=0): F+1 -> sum_q=0x0, cout_q=1.
  - Slice 2 (start=0): 9+7+1 -> sum_q=0x1, cout_q=1. Full result 0x110.
- Serial gap: same as previous, but in_valid=0 for 3 cycles between slices -> identical results; out_valid low during the gap.
- Reset mid-serial: after slice 1 (cout_q=1), pulse rst_n=0; slice 2 without start, a=9, b=7 -> sum_q=0x0, cout_q=1 (carry-in 0).
